muldiv_seq: RTL and testbench

//  Iterative RV64M multiply/divide sequencer beside the execute-stage ALU.

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 166 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            busy;

  modport master (
    output flush, in_valid, op, word, a, b, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  flush, in_valid, op, word, a, b, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply and restoring
// divide, one op in flight, result held until the pipeline takes it.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            last_q;
  logic [2:0]      op_q;
  logic            word_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] acc_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_data_q;

  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  logic            signed_d, a_neg_d, b_neg_d, ovf_d, special_d;
  logic [XLEN-1:0] a_n_d, b_n_d, a_neg_val_d, b_neg_val_d, a_mag_d, b_mag_d, spec_res_d;

  always_comb begin
    a_n_d       = bus.word ? {{(XLEN-32){1'b0}}, bus.a[31:0]} : bus.a;
    b_n_d       = bus.word ? {{(XLEN-32){1'b0}}, bus.b[31:0]} : bus.b;
    signed_d    = (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg_d     = signed_d && (bus.word ? bus.a[31] : bus.a[XLEN-1]);
    b_neg_d     = signed_d && (bus.word ? bus.b[31] : bus.b[XLEN-1]);
    a_neg_val_d = -a_n_d;
    b_neg_val_d = -b_n_d;
    a_mag_d     = !a_neg_d ? a_n_d :
                  bus.word ? {{(XLEN-32){1'b0}}, a_neg_val_d[31:0]} : a_neg_val_d;
    b_mag_d     = !b_neg_d ? b_n_d :
                  bus.word ? {{(XLEN-32){1'b0}}, b_neg_val_d[31:0]} : b_neg_val_d;
    ovf_d       = signed_d &&
                  (bus.word ? (bus.a[31:0] == 32'h8000_0000 && bus.b[31:0] == 32'hFFFF_FFFF)
                            : (bus.a == {1'b1, {(XLEN-1){1'b0}}} && bus.b == '1));
    // Ops whose result is known up front bypass the iterative datapath.
    special_d   = 1'b1;
    spec_res_d  = '0;
    if (bus.op > OP_REMU) begin
      spec_res_d = '0;
    end else if (bus.op != OP_MUL && b_n_d == '0) begin
      spec_res_d = (bus.op == OP_DIV || bus.op == OP_DIVU) ? '1 : sext(bus.a, bus.word);
    end else if (ovf_d) begin
      spec_res_d = (bus.op == OP_DIV) ? sext(bus.a, bus.word) : '0;
    end else begin
      special_d = 1'b0;
    end
  end

  logic [XLEN:0]   rem_sh_d, rem_sub_d;
  logic [XLEN-1:0] quo_d, rem_d, fin_d;

  always_comb begin
    rem_sh_d  = {acc_q, opa_q[XLEN-1]};
    rem_sub_d = rem_sh_d - {1'b0, opb_q};
    quo_d     = qneg_q ? -opa_q : opa_q;
    rem_d     = rneg_q ? -acc_q : acc_q;
    case (op_q)
      OP_MUL:          fin_d = sext(acc_q, word_q);
      OP_DIV, OP_DIVU: fin_d = sext(quo_d, word_q);
      default:         fin_d = sext(rem_d, word_q);
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.flush && !reset;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      op_q        <= OP_MUL;
      word_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            op_q   <= bus.op;
            word_q <= bus.word;
            acc_q  <= '0;
            qneg_q <= a_neg_d ^ b_neg_d;
            rneg_q <= a_neg_d;
            if (bus.op == OP_MUL) begin
              opa_q <= a_n_d;
              opb_q <= b_n_d;
            end else begin
              // Word dividends are left-aligned so the shift-out bit is always the MSB.
              opa_q <= bus.word ? (a_mag_d << (XLEN-32)) : a_mag_d;
              opb_q <= b_mag_d;
            end
            if (special_d) begin
              out_data_q <= spec_res_d;
              state_q    <= DONE;
            end else begin
              cnt_q   <= bus.word ? CW'(31) : CW'(XLEN-1);
              last_q  <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (last_q) begin
            out_data_q  <= fin_d;
            out_valid_q <= 1'b1;
            last_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            if (op_q == OP_MUL) begin
              if (opa_q[0]) acc_q <= acc_q + opb_q;
              opa_q <= opa_q >> 1;
              opb_q <= opb_q << 1;
            end else begin
              acc_q <= rem_sub_d[XLEN] ? rem_sh_d[XLEN-1:0] : rem_sub_d[XLEN-1:0];
              opa_q <= {opa_q[XLEN-2:0], ~rem_sub_d[XLEN]};
            end
            if (cnt_q == '0) last_q <= 1'b1;
            else             cnt_q  <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, special cases,
// flush/reset behaviour and the result handshake.
module tb_muldiv_seq;
  localparam int XLEN = 64;
  localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic w, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] e, input int lat,
                              input string nm);
    vec_t v;
    v.op = op; v.w = w; v.a = a; v.b = b; v.exp = e; v.lat = lat; v.name = nm;
    return v;
  endfunction

  // All driver tasks are entered and left just after a falling edge.
  task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1; bus.op = op; bus.word = w; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.word = ~w;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take_result(output logic [63:0] d);
    d = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 64'd0) begin n_fail++; $display("FAIL reset out_data: got %h expected 0", bus.out_data); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0", bus.in_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_mul();
    vec_t v[$];
    logic [63:0] d;
    int lat;
    v.push_back(mk(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7x-3"));
    v.push_back(mk(MUL, 1'b1, 64'h0000_0000_8000_0000, 64'd2, 64'd0, 33, "mulw_wrap"));
    v.push_back(mk(MUL, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_sext"));
    v.push_back(mk(MUL, 1'b0, 64'h0000_0001_0000_0001, 64'd3, 64'h0000_0003_0000_0003, 65, "mul_wide"));
    v.push_back(mk(MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, "mul_-1x-1"));
    foreach (v[i]) begin
      start_op(v[i].op, v[i].w, v[i].a, v[i].b);
      wait_valid(lat);
      take_result(d);
      n_tests++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
      n_tests++; if (d !== v[i].exp) begin n_fail++; $display("FAIL %s data: got %h expected %h", v[i].name, d, v[i].exp); end
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    logic [63:0] d;
    int lat;
    v.push_back(mk(DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_-7/2"));
    v.push_back(mk(REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_-7/2"));
    v.push_back(mk(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65, "divu_-1/2"));
    v.push_back(mk(DIV,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7/-2"));
    v.push_back(mk(REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem_7/-2"));
    v.push_back(mk(REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65, "remu_100/7"));
    v.push_back(mk(DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, "divu_min/max"));
    v.push_back(mk(DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, "divuw"));
    v.push_back(mk(DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw_-7/2"));
    v.push_back(mk(REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_-7/2"));
    foreach (v[i]) begin
      start_op(v[i].op, v[i].w, v[i].a, v[i].b);
      wait_valid(lat);
      take_result(d);
      n_tests++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
      n_tests++; if (d !== v[i].exp) begin n_fail++; $display("FAIL %s data: got %h expected %h", v[i].name, d, v[i].exp); end
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    logic [63:0] d;
    int lat;
    v.push_back(mk(DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by_0"));
    v.push_back(mk(REM,  1'b0, 64'd5, 64'd0, 64'd5, 1, "rem_by_0"));
    v.push_back(mk(DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_ovf"));
    v.push_back(mk(REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf"));
    v.push_back(mk(DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"));
    v.push_back(mk(DIVU, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divuw_by_0"));
    v.push_back(mk(REMU, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1, "remuw_by_0"));
    v.push_back(mk(3'd5, 1'b0, 64'd3, 64'd4, 64'd0, 1, "reserved_op"));
    foreach (v[i]) begin
      start_op(v[i].op, v[i].w, v[i].a, v[i].b);
      wait_valid(lat);
      take_result(d);
      n_tests++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat); end
      n_tests++; if (d !== v[i].exp) begin n_fail++; $display("FAIL %s data: got %h expected %h", v[i].name, d, v[i].exp); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] d;
    int lat;
    bit seen;
    start_op(DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_calc busy: got %b expected 0", bus.busy); end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_calc out_valid: got %b expected 0", seen); end
    start_op(DIVU, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    take_result(d);
    n_tests++; if (lat !== 65) begin n_fail++; $display("FAIL after_flush latency: got %0d expected 65", lat); end
    n_tests++; if (d !== 64'd14) begin n_fail++; $display("FAIL after_flush data: got %h expected e", d); end
    // A pending result is dropped by flush.
    start_op(MUL, 1'b0, 64'd3, 64'd3);
    wait_valid(lat);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_done busy: got %b expected 0", bus.busy); end
    // Flush and a request in the same cycle: no accept.
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = MUL; bus.word = 1'b0; bus.a = 64'd2; bus.b = 64'd2;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_accept in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_hold();
    int lat;
    start_op(MUL, 1'b0, 64'd6, 64'd7);
    wait_valid(lat);
    n_tests++; if (lat !== 65) begin n_fail++; $display("FAIL hold latency: got %0d expected 65", lat); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_tests++; if (bus.out_data !== 64'd42) begin n_fail++; $display("FAIL hold out_data[%0d]: got %h expected 2a", i, bus.out_data); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = MUL; bus.word = 1'b0; bus.a = 64'd1; bus.b = 64'd1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL handshake in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL handshake no_accept busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL handshake out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL handshake in_ready after: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    int lat;
    start_op(DIVU, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    take_result(d);
    n_tests++; if (d !== 64'd14) begin n_fail++; $display("FAIL b2b first data: got %h expected e", d); end
    start_op(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_valid(lat);
    take_result(d);
    n_tests++; if (lat !== 65) begin n_fail++; $display("FAIL b2b second latency: got %0d expected 65", lat); end
    n_tests++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL b2b second data: got %h expected ffffffffffffffff", d); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] d;
    int lat;
    start_op(MUL, 1'b0, 64'd6, 64'd7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (bus.out_data !== 64'd0) begin n_fail++; $display("FAIL midreset out_data: got %h expected 0", bus.out_data); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid: got %b expected 0", bus.out_valid); end
    start_op(MUL, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(lat);
    take_result(d);
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL midreset recover latency: got %0d expected 33", lat); end
    n_tests++; if (d !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL midreset recover data: got %h expected fffffffffffffffd", d); end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'd0; bus.word = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
